// File: rtl/max_pool1d_stream_ctrl_pkg.sv
// Shared sizing helpers for the 1-D max-pool stream controller.
package pool_pkg;

    function automatic int out_len(input int l, input int k, input int s);
        return (l - k) / s + 1;
    endfunction

    // Bits needed for a counter holding 0..n-1.
    function automatic int cnt_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    function automatic bit cfg_ok(input int l, input int k, input int s);
        return (k >= 1) && (k <= l) && (s >= 1);
    endfunction

endpackage

// File: rtl/max_pool1d_stream_ctrl_if.sv
// Valid/ready stream bundle: serial activations in, window maxima out.
interface max_pool1d_stream_ctrl_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] data_in_0;
    logic             data_in_0_valid;
    logic             data_in_0_ready;
    logic [WIDTH-1:0] data_out_0;
    logic             data_out_0_valid;
    logic             data_out_0_ready;
    logic             data_out_0_last;

    modport slave (
        input  data_in_0, data_in_0_valid, data_out_0_ready,
        output data_in_0_ready, data_out_0, data_out_0_valid, data_out_0_last
    );

    modport master (
        output data_in_0, data_in_0_valid, data_out_0_ready,
        input  data_in_0_ready, data_out_0, data_out_0_valid, data_out_0_last
    );
endinterface

// File: rtl/max_pool1d_stream_ctrl_max_tree.sv
// Combinational signed maximum over N packed elements.
module max_tree #(
    parameter int WIDTH = 8,
    parameter int N     = 2
) (
    input  logic [N-1:0][WIDTH-1:0] vals,
    output logic [WIDTH-1:0]        result
);
    always_comb begin
        result = vals[0];
        for (int i = 1; i < N; i++) begin
            if ($signed(vals[i]) > $signed(result)) result = vals[i];
        end
    end
endmodule

// File: rtl/max_pool1d_stream_ctrl.sv
// Streaming 1-D max-pool: per-row K/S windowing over a serial stream with a
// single output register giving full throughput under valid/ready.
module max_pool1d_stream_ctrl
    import pool_pkg::*;
#(
    parameter int DATA_IN_0_PRECISION_0       = 8,
    parameter int DATA_IN_0_PRECISION_1       = 3,
    parameter int DATA_IN_0_TENSOR_SIZE_DIM_0 = 8,
    parameter int DATA_IN_0_TENSOR_SIZE_DIM_1 = 1,
    parameter int KERNEL_SIZE                 = 2,
    parameter int STRIDE                      = 2,
    parameter int DATA_OUT_0_PRECISION_0      = 8,
    parameter int DATA_OUT_0_PRECISION_1      = 3
) (
    input logic                    clk,
    input logic                    rst,
    max_pool1d_stream_ctrl_if.slave bus
);
    localparam int W       = DATA_IN_0_PRECISION_0;
    localparam int L       = DATA_IN_0_TENSOR_SIZE_DIM_0;
    localparam int R       = DATA_IN_0_TENSOR_SIZE_DIM_1;
    localparam int K       = KERNEL_SIZE;
    localparam int S       = STRIDE;
    localparam int OUT_LEN = out_len(L, K, S);
    localparam int PW      = cnt_w(L);
    localparam int SW      = cnt_w(S);
    localparam int OW      = cnt_w(OUT_LEN + 1);
    localparam int RW      = cnt_w(R);
    localparam int WD      = (K > 1) ? K - 1 : 1;

    if (DATA_OUT_0_PRECISION_0 != DATA_IN_0_PRECISION_0 ||
        DATA_OUT_0_PRECISION_1 != DATA_IN_0_PRECISION_1) begin : g_prec_chk
        $error("max_pool1d_stream_ctrl: output precision must equal input precision");
    end
    if (!cfg_ok(L, K, S)) begin : g_cfg_chk
        $error("max_pool1d_stream_ctrl: need 1 <= KERNEL_SIZE <= row length and STRIDE >= 1");
    end

    logic [PW-1:0]        pos_cnt;
    logic [SW-1:0]        stride_cnt;
    logic [OW-1:0]        out_cnt;
    logic [RW-1:0]        row_cnt;
    logic [WD-1:0][W-1:0] win;
    logic [K-1:0][W-1:0]  tree_in;
    logic [W-1:0]         win_max;
    logic [W-1:0]         out_data;
    logic                 out_valid, out_last;
    logic                 accept, fire, row_end;

    assign bus.data_in_0_ready  = !rst && (!out_valid || bus.data_out_0_ready);
    assign bus.data_out_0       = out_data;
    assign bus.data_out_0_valid = out_valid;
    assign bus.data_out_0_last  = out_last;

    assign accept  = bus.data_in_0_valid && bus.data_in_0_ready;
    assign row_end = accept && (pos_cnt == PW'(L - 1));
    assign fire    = accept && (pos_cnt >= PW'(K - 1)) && (stride_cnt == '0)
                     && (out_cnt < OW'(OUT_LEN));

    // Window = incoming element plus the K-1 most recent accepted elements.
    assign tree_in[0] = bus.data_in_0;
    for (genvar i = 1; i < K; i++) begin : g_tap
        assign tree_in[i] = win[i-1];
    end

    max_tree #(.WIDTH(W), .N(K)) u_max_tree (
        .vals   (tree_in),
        .result (win_max)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            win <= '0;
        end else if (accept) begin
            win[0] <= bus.data_in_0;
            for (int i = 1; i < WD; i++) win[i] <= win[i-1];
        end
    end

    // Stale window entries from the previous row are masked by the pos_cnt gate.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pos_cnt    <= '0;
            stride_cnt <= '0;
            out_cnt    <= '0;
            row_cnt    <= '0;
        end else if (accept) begin
            if (row_end) begin
                pos_cnt    <= '0;
                stride_cnt <= '0;
                out_cnt    <= '0;
                row_cnt    <= (row_cnt == RW'(R - 1)) ? '0 : row_cnt + 1'b1;
            end else begin
                pos_cnt <= pos_cnt + 1'b1;
                if (pos_cnt >= PW'(K - 1))
                    stride_cnt <= (stride_cnt == SW'(S - 1)) ? '0 : stride_cnt + 1'b1;
                if (fire) out_cnt <= out_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
        end else if (fire) begin
            out_valid <= 1'b1;
            out_data  <= win_max;
            out_last  <= (out_cnt == OW'(OUT_LEN - 1)) && (row_cnt == RW'(R - 1));
        end else if (bus.data_out_0_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_max_pool1d_stream_ctrl.sv
// Bench for max_pool1d_stream_ctrl: five configurations checked every cycle
// against a row/position-level window model, plus literal pins.
module tb_max_pool1d_stream_ctrl;
    localparam int NI = 5;
    localparam int CL[NI] = '{8, 5, 7, 4, 6};
    localparam int CK[NI] = '{2, 3, 2, 2, 1};
    localparam int CS[NI] = '{2, 1, 2, 2, 2};
    localparam int CR[NI] = '{1, 1, 1, 2, 1};

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] in_data[NI];
    logic       in_valid[NI];
    logic       in_ready[NI];
    logic       out_ready[NI];
    logic [7:0] out_data[NI];
    logic       out_valid[NI];
    logic       out_last[NI];

    int total = 0;
    int bad   = 0;

    // Model state: current row contents by position, pending expected output.
    int rbuf[NI][16];
    int mpos[NI];
    int mrow[NI];
    bit pv[NI];
    int pd[NI];
    bit pl[NI];
    int log_d[NI][64];
    bit log_l[NI][64];
    int log_n[NI];

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        max_pool1d_stream_ctrl_if #(.WIDTH(8)) bus ();
        assign bus.data_in_0        = in_data[g];
        assign bus.data_in_0_valid  = in_valid[g];
        assign bus.data_out_0_ready = out_ready[g];
        assign in_ready[g]          = bus.data_in_0_ready;
        assign out_data[g]          = bus.data_out_0;
        assign out_valid[g]         = bus.data_out_0_valid;
        assign out_last[g]          = bus.data_out_0_last;

        max_pool1d_stream_ctrl #(
            .DATA_IN_0_PRECISION_0       (8),
            .DATA_IN_0_PRECISION_1       (3),
            .DATA_IN_0_TENSOR_SIZE_DIM_0 (CL[g]),
            .DATA_IN_0_TENSOR_SIZE_DIM_1 (CR[g]),
            .KERNEL_SIZE                 (CK[g]),
            .STRIDE                      (CS[g]),
            .DATA_OUT_0_PRECISION_0      (8),
            .DATA_OUT_0_PRECISION_1      (3)
        ) dut (
            .clk (clk),
            .rst (rst),
            .bus (bus)
        );
    end

    task automatic chk(input int g, input string nm, input logic signed [31:0] act,
                       input logic signed [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s inst=%0d got=%0d want=%0d t=%0t", nm, g, act, exp, $time);
        end
    endtask

    task automatic model_accept(input int g, input int v);
        int first, mx;
        rbuf[g][mpos[g]] = v;
        first = mpos[g] - CK[g] + 1;
        if (first >= 0 && (first % CS[g]) == 0) begin
            mx = rbuf[g][first];
            for (int i = first + 1; i <= mpos[g]; i++)
                if (rbuf[g][i] > mx) mx = rbuf[g][i];
            if (pv[g]) chk(g, "model_overflow", 1, 0);
            pv[g] = 1'b1;
            pd[g] = mx;
            pl[g] = (first / CS[g] == (CL[g] - CK[g]) / CS[g]) && (mrow[g] == CR[g] - 1);
        end
        mpos[g]++;
        if (mpos[g] == CL[g]) begin
            mpos[g] = 0;
            mrow[g] = (mrow[g] + 1) % CR[g];
        end
    endtask

    task automatic monitor_cycle();
        bit acc;
        for (int g = 0; g < NI; g++) begin
            if (rst) begin
                chk(g, "rst_valid", out_valid[g], 0);
                chk(g, "rst_data", out_data[g], 0);
                chk(g, "rst_last", out_last[g], 0);
                chk(g, "rst_in_ready", in_ready[g], 0);
                mpos[g] = 0;
                mrow[g] = 0;
                pv[g]   = 1'b0;
            end else begin
                chk(g, "in_ready", in_ready[g], !pv[g] || out_ready[g]);
                chk(g, "out_valid", out_valid[g], pv[g]);
                if (pv[g]) begin
                    chk(g, "out_data", $signed(out_data[g]), pd[g]);
                    chk(g, "out_last", out_last[g], pl[g]);
                end
                acc = in_valid[g] && (!pv[g] || out_ready[g]);
                if (pv[g] && out_ready[g]) begin
                    log_d[g][log_n[g] % 64] = pd[g];
                    log_l[g][log_n[g] % 64] = pl[g];
                    log_n[g]++;
                    pv[g] = 1'b0;
                end
                if (acc) model_accept(g, int'($signed(in_data[g])));
            end
        end
    endtask

    task automatic send(input int g, input int v);
        in_data[g]  = 8'(v);
        in_valid[g] = 1'b1;
        for (int t = 0; ; t++) begin
            @(negedge clk);
            if (in_ready[g]) break;
            if (t > 200) begin
                chk(g, "send_timeout", 0, 1);
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send_list(input int g, input int vals[16], input int n);
        for (int i = 0; i < n; i++) send(g, vals[i]);
        in_valid[g] = 1'b0;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic pins(input int g, input string nm, input int st, input int ed[8],
                        input bit el[8], input int n);
        chk(g, {nm, "_count"}, log_n[g] - st, n);
        for (int i = 0; i < n; i++) begin
            chk(g, {nm, "_data"}, log_d[g][(st + i) % 64], ed[i]);
            chk(g, {nm, "_last"}, log_l[g][(st + i) % 64], el[i]);
        end
    endtask

    task automatic do_reset(input int cycles);
        rst = 1'b1;
        repeat (cycles) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        int st;
        bit done;
        for (int g = 0; g < NI; g++) begin
            in_data[g]   = '0;
            in_valid[g]  = 1'b0;
            out_ready[g] = 1'b1;
            log_n[g]     = 0;
            mpos[g]      = 0;
            mrow[g]      = 0;
            pv[g]        = 1'b0;
        end
        fork
            forever begin
                @(negedge clk);
                monitor_cycle();
            end
        join_none

        // Reset with a valid beat presented: nothing may be accepted.
        in_valid[0] = 1'b1;
        in_data[0]  = 8'd77;
        repeat (3) @(posedge clk);
        #1;
        in_valid[0] = 1'b0;
        rst = 1'b0;
        @(posedge clk);
        #1;

        st = log_n[0];
        send_list(0, '{1,2,3,4,5,6,7,8,0,0,0,0,0,0,0,0}, 8);
        pins(0, "basic", st, '{2,4,6,8,0,0,0,0}, '{0,0,0,1,0,0,0,0}, 4);

        st = log_n[1];
        send_list(1, '{3,-1,5,0,2,0,0,0,0,0,0,0,0,0,0,0}, 5);
        pins(1, "signed", st, '{5,5,5,0,0,0,0,0}, '{0,0,1,0,0,0,0,0}, 3);

        st = log_n[2];
        send_list(2, '{1,2,3,4,5,6,7,0,0,0,0,0,0,0,0,0}, 7);
        pins(2, "tail", st, '{2,4,6,0,0,0,0,0}, '{0,0,1,0,0,0,0,0}, 3);
        st = log_n[2];
        send_list(2, '{-4,-9,0,0,0,0,0,0,0,0,0,0,0,0,0,0}, 2);
        pins(2, "wrap", st, '{-4,0,0,0,0,0,0,0}, '{0,0,0,0,0,0,0,0}, 1);
        // finish that row so later traffic starts at position 0
        send_list(2, '{1,1,1,1,1,0,0,0,0,0,0,0,0,0,0,0}, 5);

        st = log_n[3];
        send_list(3, '{9,1,2,8,0,7,7,3,0,0,0,0,0,0,0,0}, 8);
        pins(3, "rows", st, '{9,8,7,7,0,0,0,0}, '{0,0,0,1,0,0,0,0}, 4);

        st = log_n[4];
        send_list(4, '{5,-3,7,1,-8,2,0,0,0,0,0,0,0,0,0,0}, 6);
        pins(4, "k1", st, '{5,7,-8,0,0,0,0,0}, '{0,0,1,0,0,0,0,0}, 3);

        // Backpressure: hold ready low for 5 cycles once output 2 appears.
        st = log_n[0];
        fork
            send_list(0, '{1,2,3,4,5,6,7,8,0,0,0,0,0,0,0,0}, 8);
            begin
                int t;
                t = 0;
                while (!(out_valid[0] && out_data[0] == 8'd2) && t < 100) begin
                    @(posedge clk);
                    #1;
                    t++;
                end
                chk(0, "bp_seen", t < 100, 1);
                out_ready[0] = 1'b0;
                repeat (5) begin
                    @(negedge clk);
                    chk(0, "bp_in_ready", in_ready[0], 0);
                    chk(0, "bp_hold", out_data[0], 2);
                end
                @(posedge clk);
                #1;
                out_ready[0] = 1'b1;
            end
        join
        repeat (3) @(posedge clk);
        #1;
        pins(0, "bp", st, '{2,4,6,8,0,0,0,0}, '{0,0,0,1,0,0,0,0}, 4);

        // Reset mid-row after beat 3.
        send(0, 1);
        send(0, 2);
        send(0, 3);
        in_valid[0] = 1'b0;
        do_reset(2);
        st = log_n[0];
        send_list(0, '{1,2,3,4,5,6,7,8,0,0,0,0,0,0,0,0}, 8);
        pins(0, "rst_mid", st, '{2,4,6,8,0,0,0,0}, '{0,0,0,1,0,0,0,0}, 4);

        // Randomized traffic with valid gaps and random backpressure.
        for (int g = 0; g < NI; g++) begin
            done = 1'b0;
            fork
                begin
                    for (int i = 0; i < 4 * CL[g] * CR[g]; i++) begin
                        if ($urandom_range(0, 3) == 0) begin
                            in_valid[g] = 1'b0;
                            @(posedge clk);
                            #1;
                        end
                        send(g, int'($urandom_range(0, 255)));
                    end
                    in_valid[g] = 1'b0;
                    done = 1'b1;
                end
                begin
                    while (!done) begin
                        out_ready[g] = ($urandom_range(0, 3) != 0);
                        @(posedge clk);
                        #1;
                    end
                    out_ready[g] = 1'b1;
                end
            join
            repeat (4) @(posedge clk);
            #1;
        end

        for (int g = 0; g < NI; g++) chk(g, "drained", pv[g], 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
